// File: rtl/seq_divider_pkg.sv
//==============================================================================
// Module      : seq_divider_pkg
// Description : Shared constants for the iterative non-restoring divider.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package seq_divider_pkg;

    localparam int c_default_width = 32;
    localparam int c_cnt_width     = $clog2(c_default_width) + 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_iter = 2'd1;
    localparam logic [1:0] c_fix  = 2'd2;
    localparam logic [1:0] c_done = 2'd3;

    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_addsub_step.sv
//==============================================================================
// Module      : div_addsub_step
// Description : Combinational (WIDTH+1)-bit add/subtract step (b inverted, carry-in = sub).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module div_addsub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    input  logic           sub,
    output logic [WIDTH:0] sum
);

    logic [WIDTH:0] w_b_inv;

    assign w_b_inv = b ^ {(WIDTH + 1){sub}};
    assign sum     = a + w_b_inv + {{WIDTH{1'b0}}, sub};

endmodule

`default_nettype wire

// File: rtl/seq_divider.sv
//==============================================================================
// Module      : seq_divider
// Description : Iterative non-restoring divider, one add/sub per clock, start/done
//               handshake. Define SEQ_DIVIDER_SIGNED_EN for the signed_op port.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SEQ_DIVIDER_SIGNED_EN
    input  logic             signed_op,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int c_cw = cnt_width(WIDTH);

    logic [1:0]       r_state, w_next_state;
    logic [c_cw-1:0]  r_cnt;
    logic [WIDTH:0]   r_p;
    logic [WIDTH-1:0] r_q, r_d;
    logic             r_dz;
    logic [WIDTH-1:0] r_quotient, r_remainder;
    logic             r_div_by_zero;

    logic [WIDTH:0]   w_a, w_b, w_sum;
    logic             w_sub;
    logic             w_dvs_zero;
    logic [WIDTH-1:0] w_dvd_mag, w_dvs_mag;
    logic [WIDTH-1:0] w_rem_pos, w_q_fix, w_r_fix;

    assign w_dvs_zero = (divisor == '0);
    assign w_rem_pos  = r_p[WIDTH] ? w_sum[WIDTH-1:0] : r_p[WIDTH-1:0];

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic w_dvd_neg, w_dvs_neg, r_neg_q, r_neg_r;

    assign w_dvd_neg = signed_op & dividend[WIDTH-1];
    assign w_dvs_neg = signed_op & divisor[WIDTH-1];
    assign w_dvd_mag = w_dvd_neg ? -dividend : dividend;
    assign w_dvs_mag = w_dvs_neg ? -divisor  : divisor;
    // Most-negative / -1 falls out naturally: the magnitude wraps back to itself.
    assign w_q_fix   = r_neg_q ? -r_q      : r_q;
    assign w_r_fix   = r_neg_r ? -w_rem_pos : w_rem_pos;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (r_state == c_idle && start) begin
            r_neg_q <= w_dvd_neg ^ w_dvs_neg;
            r_neg_r <= w_dvd_neg;
        end
    end
`else
    assign w_dvd_mag = dividend;
    assign w_dvs_mag = divisor;
    assign w_q_fix   = r_q;
    assign w_r_fix   = w_rem_pos;
`endif

    // ITER feeds the shifted {P,Q}; FIX reuses the same adder to restore P.
    always_comb begin
        w_a   = r_p;
        w_b   = {1'b0, r_d};
        w_sub = 1'b0;
        if (r_state == c_iter) begin
            w_a   = {r_p[WIDTH-1:0], r_q[WIDTH-1]};
            w_sub = ~r_p[WIDTH];
        end
    end

    div_addsub_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a   (w_a),
        .b   (w_b),
        .sub (w_sub),
        .sum (w_sum)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_idle:  if (start) w_next_state = w_dvs_zero ? c_fix : c_iter;
            c_iter:  if (r_cnt == c_cw'(1)) w_next_state = c_fix;
            c_fix:   w_next_state = c_done;
            c_done:  w_next_state = c_idle;
            default: w_next_state = c_idle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= c_idle;
            r_cnt         <= '0;
            r_p           <= '0;
            r_q           <= '0;
            r_d           <= '0;
            r_dz          <= 1'b0;
            r_quotient    <= '0;
            r_remainder   <= '0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                c_idle: begin
                    if (start) begin
                        r_cnt <= c_cw'(WIDTH);
                        r_p   <= '0;
                        r_d   <= w_dvs_mag;
                        r_dz  <= w_dvs_zero;
                        // A zero divisor keeps the raw dividend for the remainder.
                        r_q   <= w_dvs_zero ? dividend : w_dvd_mag;
                    end
                end
                c_iter: begin
                    r_p   <= w_sum;
                    r_q   <= {r_q[WIDTH-2:0], ~w_sum[WIDTH]};
                    r_cnt <= r_cnt - c_cw'(1);
                end
                c_fix: begin
                    r_div_by_zero <= r_dz;
                    if (r_dz) begin
                        r_quotient  <= '1;
                        r_remainder <= r_q;
                    end else begin
                        r_quotient  <= w_q_fix;
                        r_remainder <= w_r_fix;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state == c_iter) || (r_state == c_fix);
    assign done        = (r_state == c_done);
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_div_by_zero;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//==============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider (WIDTH=32); signed cases
//               are exercised when SEQ_DIVIDER_SIGNED_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy, done, div_by_zero;
    logic [31:0] quotient, remainder;

    int n_checks = 0;
    int n_errors = 0;
    int busy_cycles;
    int done_seen;

    always #5 clk = ~clk;

    seq_divider #(
        .WIDTH (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
`ifdef SEQ_DIVIDER_SIGNED_EN
        .signed_op   (signed_op),
`endif
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected)
        else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer division semantics, zero divisor and signed overflow special-cased.
    function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic s,
                                  output logic [31:0] q, output logic [31:0] r, output logic dz);
        dz = (b == 32'd0);
        if (dz) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else if (s) begin
            q = 32'($signed(a) / $signed(b));
            r = 32'($signed(a) % $signed(b));
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    // Counts cycles (from first_cycle) until done, sampling on the falling edge.
    task automatic wait_done(input int first_cycle, output int lat);
        lat = -1;
        for (int c = first_cycle; c < first_cycle + 80; c++) begin
            @(negedge clk);
            if (done) begin
                lat = c;
                check("busy_at_done", 32'(busy), 32'd0);
                return;
            end
            if (busy) busy_cycles++;
        end
        check("done_timeout", 32'd0, 32'd1);
    endtask

    // Cycle 0 is the cycle whose closing edge samples start.
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic s);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        signed_op = s;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        busy_cycles = 0;
    endtask

    task automatic run_check(input string tag, input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] eq, er;
        logic        edz;
        int          lat;
        model(a, b, s, eq, er, edz);
        accept(a, b, s);
        wait_done(1, lat);
        check({tag, "_lat"}, 32'(lat), (b == 32'd0) ? 32'd2 : 32'd34);
        check({tag, "_q"}, quotient, eq);
        check({tag, "_r"}, remainder, er);
        check({tag, "_dz"}, 32'(div_by_zero), 32'(edz));
    endtask

    initial begin
        int lat;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_q", quotient, 32'd0);
        check("rst_r", remainder, 32'd0);
        check("rst_dz", 32'(div_by_zero), 32'd0);

        run_check("d100_7", 32'd100, 32'd7, 1'b0);
        check("d100_7_busy_cycles", 32'(busy_cycles), 32'd33);

        run_check("ffff_1", 32'hFFFF_FFFF, 32'd1, 1'b0);
        run_check("d3_10", 32'd3, 32'd10, 1'b0);
        run_check("msb_msb", 32'h8000_0000, 32'h8000_0000, 1'b0);

        run_check("d5_0", 32'd5, 32'd0, 1'b0);
        run_check("d9_3", 32'd9, 32'd3, 1'b0);

        // A second start in cycle 10 must be dropped.
        accept(32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        @(negedge clk);
        dividend = 32'd20;
        divisor  = 32'd4;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(11, lat);
        check("ign_lat", 32'(lat), 32'd34);
        check("ign_q", quotient, 32'd14);
        check("ign_r", remainder, 32'd2);
        // Start in the cycle right after done is accepted.
        run_check("after_done", 32'd20, 32'd4, 1'b0);
        repeat (3) @(negedge clk);
        check("hold_q", quotient, 32'd5);
        check("hold_r", remainder, 32'd0);

        // Reset in cycle 15 aborts the operation with no done.
        accept(32'd100, 32'd7, 1'b0);
        done_seen = 0;
        for (int c = 1; c < 15; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_q", quotient, 32'd0);
        check("abort_r", remainder, 32'd0);
        check("abort_dz", 32'(div_by_zero), 32'd0);
        repeat (40) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("abort_no_done", 32'(done_seen), 32'd0);
        run_check("d50_8", 32'd50, 32'd8, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            run_check($sformatf("rnd%0d", i), ra, rb, 1'b0);
        end

`ifdef SEQ_DIVIDER_SIGNED_EN
        run_check("s_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1);
        check("s_m7_2_q_lit", quotient, 32'hFFFF_FFFD);
        check("s_m7_2_r_lit", remainder, 32'hFFFF_FFFF);
        run_check("s_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1);
        check("s_7_m2_q_lit", quotient, 32'hFFFF_FFFD);
        check("s_7_m2_r_lit", remainder, 32'd1);
        run_check("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_check("s_dz", 32'hFFFF_FFF0, 32'd0, 1'b1);
        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 0) rb = -rb;
            run_check($sformatf("srnd%0d", i), ra, rb, 1'b1);
        end
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
